iq2phase: RTL

Upstream stage of `phase2speed` in the Hilbert demodulation chain. Takes the analytic-signal pair (I = delayed input, Q = Hilbert filter output) and computes the phase angle with an iterative vectoring-mode CORDIC. With the delta feature compiled in, it outputs the wrapped phase increment per sample. Output format and strobe match the `phase` / `sample` inputs of `phase2speed`.

---
 rtl/hilbert_pkg.sv | 49 ++++
 rtl/cordic_vec_step.sv | 35 +++
 rtl/iq2phase.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hilbert_pkg.sv
// Shared constants, types and the CORDIC arctangent table for the
// Hilbert demodulation chain (iq2phase -> phase2speed).
package hilbert_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ANGLE_W  = 24;
    localparam int PHASE_W  = 19;
    localparam int XY_W     = 18;

    localparam logic signed [ANGLE_W-1:0] PI_Q20      = 24'sd3294199;
    localparam logic signed [ANGLE_W-1:0] HALF_PI_Q20 = 24'sd1647099;

    localparam logic signed [PHASE_W:0] PI_Q10     = 20'sd3217;
    localparam logic signed [PHASE_W:0] TWO_PI_Q10 = 20'sd6434;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_ROT,
        ST_OUT
    } state_t;

    // atan(2^-k) in Q20 radians
    function automatic logic signed [ANGLE_W-1:0] atan_q20(
        input logic [3:0] k
    );
        logic signed [ANGLE_W-1:0] a;
        case (k)
            4'd0:    a = 24'sd823550;
            4'd1:    a = 24'sd486170;
            4'd2:    a = 24'sd256879;
            4'd3:    a = 24'sd130396;
            4'd4:    a = 24'sd65451;
            4'd5:    a = 24'sd32757;
            4'd6:    a = 24'sd16383;
            4'd7:    a = 24'sd8192;
            4'd8:    a = 24'sd4096;
            4'd9:    a = 24'sd2048;
            4'd10:   a = 24'sd1024;
            4'd11:   a = 24'sd512;
            4'd12:   a = 24'sd256;
            4'd13:   a = 24'sd128;
            4'd14:   a = 24'sd64;
            default: a = 24'sd32;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring-mode CORDIC micro-rotation, purely combinational.
// Drives y toward zero while accumulating the rotated angle in z.
module cordic_vec_step
    import hilbert_pkg::*;
(
    input  logic signed [XY_W-1:0]    x,
    input  logic signed [XY_W-1:0]    y,
    input  logic signed [ANGLE_W-1:0] z,
    input  logic        [3:0]         k,
    input  logic signed [ANGLE_W-1:0] atan,
    output logic signed [XY_W-1:0]    x_n,
    output logic signed [XY_W-1:0]    y_n,
    output logic signed [ANGLE_W-1:0] z_n
);

    logic signed [XY_W-1:0] xs;
    logic signed [XY_W-1:0] ys;

    assign xs = x >>> k;
    assign ys = y >>> k;

    // Rotate clockwise when y is non-negative, otherwise counter-clockwise
    always_comb begin
        if (!y[XY_W-1]) begin
            x_n = x + ys;
            y_n = y - xs;
            z_n = z + atan;
        end else begin
            x_n = x - ys;
            y_n = y + xs;
            z_n = z - atan;
        end
    end

endmodule

// File: rtl/iq2phase.sv
// Iterative CORDIC I/Q to phase converter, 9Q10 radian output.
// Define IQ2PHASE_DELTA_EN to output the wrapped per-sample increment.
module iq2phase
    import hilbert_pkg::*;
#(
    parameter int ITER = 14
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] i_in,
    input  logic signed [SAMPLE_W-1:0] q_in,
    output logic signed [PHASE_W-1:0]  phase,
    output logic                       sample,
    output logic                       busy,
    output logic                       overrun
);

    state_t state;

    logic signed [XY_W-1:0]    x;
    logic signed [XY_W-1:0]    y;
    logic signed [ANGLE_W-1:0] z;
    logic        [3:0]         k;
    logic                      zero_in;

    logic signed [XY_W-1:0]    x_n;
    logic signed [XY_W-1:0]    y_n;
    logic signed [ANGLE_W-1:0] z_n;

    logic signed [ANGLE_W-1:0] z_rnd;
    logic signed [ANGLE_W-1:0] z_sh;
    logic signed [PHASE_W-1:0] angle;
    logic                      last;

    cordic_vec_step u_step (
        .x    (x),
        .y    (y),
        .z    (z),
        .k    (k),
        .atan (atan_q20(k)),
        .x_n  (x_n),
        .y_n  (y_n),
        .z_n  (z_n)
    );

    assign last  = (k == 4'(ITER - 1));
    assign z_rnd = z_n + 24'sd512;
    assign z_sh  = z_rnd >>> 10;

    // Round/saturate the final Q20 angle to 9Q10; a null vector maps to 0
    always_comb begin
        angle = z_sh[PHASE_W-1:0];
        if (z_sh > 24'sd262143) begin
            angle = 19'sh3FFFF;
        end else if (z_sh < -24'sd262144) begin
            angle = 19'sh40000;
        end
        if (zero_in) begin
            angle = '0;
        end
    end

`ifdef IQ2PHASE_DELTA_EN
    logic signed [PHASE_W-1:0] prev;
    logic                      primed;
    logic signed [PHASE_W:0]   d_raw;
    logic signed [PHASE_W:0]   d_wrap;

    // Phase increment wrapped into (-pi, pi]
    always_comb begin
        d_raw  = {angle[PHASE_W-1], angle} - {prev[PHASE_W-1], prev};
        d_wrap = d_raw;
        if (d_raw > PI_Q10) begin
            d_wrap = d_raw - TWO_PI_Q10;
        end else if (d_raw < -PI_Q10) begin
            d_wrap = d_raw + TWO_PI_Q10;
        end
    end
`endif

    // Conversion FSM: capture, quadrant pre-rotate, iterate, publish
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            k       <= '0;
            zero_in <= 1'b0;
            phase   <= '0;
            sample  <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
`ifdef IQ2PHASE_DELTA_EN
            prev    <= '0;
            primed  <= 1'b0;
`endif
        end else begin
            sample  <= 1'b0;
            overrun <= 1'b0;
            case (state)
                ST_IDLE, ST_OUT: begin
                    if (in_valid) begin
                        x       <= {{2{i_in[SAMPLE_W-1]}}, i_in};
                        y       <= {{2{q_in[SAMPLE_W-1]}}, q_in};
                        zero_in <= (i_in == '0) && (q_in == '0);
                        state   <= ST_PRE;
                        busy    <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_PRE: begin
                    k     <= '0;
                    state <= ST_ROT;
                    if (!x[XY_W-1]) begin
                        z <= '0;
                    end else if (!y[XY_W-1]) begin
                        x <= y;
                        y <= -x;
                        z <= HALF_PI_Q20;
                    end else begin
                        x <= -y;
                        y <= x;
                        z <= -HALF_PI_Q20;
                    end
                end
                ST_ROT: begin
                    x <= x_n;
                    y <= y_n;
                    z <= z_n;
                    k <= k + 4'd1;
                    if (last) begin
                        state <= ST_OUT;
`ifdef IQ2PHASE_DELTA_EN
                        prev   <= angle;
                        primed <= 1'b1;
                        if (primed) begin
                            phase  <= d_wrap[PHASE_W-1:0];
                            sample <= 1'b1;
                        end
`else
                        phase  <= angle;
                        sample <= 1'b1;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (in_valid && (state == ST_PRE || state == ST_ROT)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
